// File: rtl/mul_div_ctrl_if.sv
// rtl/mul_div_ctrl_if.sv - request/response and HI/LO bundle for the mul/div controller
interface mul_div_ctrl_if;
    logic        req_valid;
    logic [12:0] req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, req_op, req_src1, req_src2, flush,
        input  req_ready, resp_valid, resp_data, busy, hi, lo
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, flush,
        output req_ready, resp_valid, resp_data, busy, hi, lo
    );
endinterface

// File: rtl/mul_div_ctrl.sv
// rtl/mul_div_ctrl.sv - HI/LO owner sequencing multiply, restoring divide and mt/mf ops
module mul_div_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           resetn,
    mul_div_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [31:0] op_a, op_b;
    logic        mul_signed;
    logic [1:0]  mul_kind;
    logic [31:0] div_q, div_r, div_d;
    logic        neg_q, neg_r;
    logic [31:0] hi_q, lo_q, resp_data_q;
    logic        resp_valid_q;

    logic [12:0] op;
    logic        op_valid, is_mul_fam, is_div_fam, accept, commit;
    logic        a_neg, b_neg;

    assign op         = bus.req_op;
    assign op_valid   = (op != 13'd0) && ((op & (op - 13'd1)) == 13'd0);
    assign is_mul_fam = op_valid && (|op[12:6]);
    assign is_div_fam = op_valid && (|op[5:4]);
    assign accept     = bus.req_valid & bus.req_ready;
    assign a_neg      = op[4] & bus.req_src1[31];
    assign b_neg      = op[4] & bus.req_src2[31];

    assign bus.req_ready  = (state == IDLE) & ~bus.flush;
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;

    // Operands are widened with their sign only for the signed ops, so one
    // 64x64 truncated product covers both signednesses modulo 2^64.
    logic [63:0] ext_a, ext_b, prod, acc, mul_result;
    assign ext_a = {{32{mul_signed & op_a[31]}}, op_a};
    assign ext_b = {{32{mul_signed & op_b[31]}}, op_b};
    assign prod  = ext_a * ext_b;
    assign acc   = {hi_q, lo_q};

    always_comb begin
        mul_result = prod;
        case (mul_kind)
            2'd1:    mul_result = acc + prod;
            2'd2:    mul_result = acc - prod;
            default: mul_result = prod;
        endcase
    end

    // One restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only when it does not borrow.
    logic [32:0] shifted;
    logic [31:0] trial, q_fix, r_fix;
    logic        take;
    assign shifted = {div_r, div_q[31]};
    assign take    = (shifted >= {1'b0, div_d});
    assign trial   = 32'(shifted - {1'b0, div_d});
    assign q_fix   = neg_q ? (32'd0 - div_q) : div_q;
    assign r_fix   = neg_r ? (32'd0 - div_r) : div_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul_fam)      state_next = MUL;
                else if (accept && is_div_fam) state_next = DIV;
            end
            MUL, DIV: begin
                if (cnt == 6'd0) begin
                    commit     = ~bus.flush;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt          <= 6'd0;
            op_a         <= 32'd0;
            op_b         <= 32'd0;
            mul_signed   <= 1'b0;
            mul_kind     <= 2'd0;
            div_q        <= 32'd0;
            div_r        <= 32'd0;
            div_d        <= 32'd0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            resp_data_q  <= 32'd0;
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (accept) begin
                if (!(is_mul_fam || is_div_fam)) begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= (op_valid && op[2]) ? hi_q :
                                    (op_valid && op[3]) ? lo_q : 32'd0;
                end
                if (op_valid && op[0]) hi_q <= bus.req_src1;
                if (op_valid && op[1]) lo_q <= bus.req_src1;
                if (is_mul_fam) begin
                    op_a       <= bus.req_src1;
                    op_b       <= bus.req_src2;
                    mul_signed <= op[6] | op[8] | op[9] | op[11];
                    mul_kind   <= op[8] ? 2'd3 : (op[9] | op[10]) ? 2'd1 :
                                  (op[11] | op[12]) ? 2'd2 : 2'd0;
                    cnt        <= 6'(MUL_LAT - 1);
                end
                if (is_div_fam) begin
                    div_q <= a_neg ? (32'd0 - bus.req_src1) : bus.req_src1;
                    div_d <= b_neg ? (32'd0 - bus.req_src2) : bus.req_src2;
                    div_r <= 32'd0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    cnt   <= 6'd32;
                end
            end else if (state == MUL && !bus.flush) begin
                if (commit) begin
                    resp_valid_q <= 1'b1;
                    if (mul_kind == 2'd3) begin
                        resp_data_q <= prod[31:0];
                    end else begin
                        resp_data_q  <= 32'd0;
                        {hi_q, lo_q} <= mul_result;
                    end
                end else begin
                    cnt <= cnt - 6'd1;
                end
            end else if (state == DIV && !bus.flush) begin
                if (commit) begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= 32'd0;
                    hi_q         <= r_fix;
                    lo_q         <= q_fix;
                end else begin
                    cnt   <= cnt - 6'd1;
                    div_q <= {div_q[30:0], take};
                    div_r <= take ? trial : shifted[31:0];
                end
            end
        end
    end
endmodule
